fetch_buffer_stage: RTL and testbench

//  Instruction fetch stage directly downstream of the program counter. Accepts PC addresses,

---
 rtl/fetch_buffer_stage.sv | 146 ++++++++++++++
 tb/tb_fetch_buffer_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer_stage.sv
// Fetch stage between the program counter and decode.
//
// Accepts byte-addressed PCs, issues word reads to a synchronous instruction memory with a
// 1-cycle read latency, and queues {pc, instr} pairs in a small FIFO. The FIFO drains to
// decode through a valid/ready handshake.
//
// Ports:
//   clock, reset           single clock; synchronous active-high reset
//   pc_in/pc_valid/pc_ready PC request handshake (pc_ready never looks at id_ready)
//   imem_en/imem_addr      memory read strobe and word address
//   imem_rdata             read data, valid the cycle after imem_en
//   flush                  redirect: drop every queued and in-flight fetch
//   id_valid/id_ready      decode handshake for the FIFO head
//   id_instr/id_pc         FIFO head entry
//   id_pc_plus4            id_pc + 4, wrapping at 2^ADDR_W
//   misalign_err           one-cycle pulse when a misaligned fetch lands in the FIFO
module fetch_buffer_stage #(
  parameter int unsigned        ADDR_W  = 8,
  parameter int unsigned        INSTR_W = 32,
  parameter int unsigned        DEPTH   = 2,
  parameter logic [INSTR_W-1:0] NOP     = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               pc_valid,
  output logic               pc_ready,
  output logic               imem_en,
  output logic [ADDR_W-3:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               flush,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus4,
  output logic               misalign_err
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  // FIFO storage
  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Outstanding memory read
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic              inflight_mis_q;

  // Last head shown to decode, held while the FIFO is empty
  logic [ADDR_W-1:0]  last_pc_q;
  logic [INSTR_W-1:0] last_instr_q;

  logic [CntW-1:0]    occupancy;
  logic               accept;
  logic               push;
  logic               pop;
  logic [INSTR_W-1:0] push_instr;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Request side. In-flight reads reserve a FIFO slot so a response always has room.
  always_comb begin
    occupancy = count_q + CntW'(inflight_q);
    pc_ready  = !reset && !flush && (occupancy < CntW'(DEPTH));
    accept    = pc_valid && pc_ready;
    imem_en   = accept;
    imem_addr = pc_in[ADDR_W-1:2];
  end

  // Response and drain side
  always_comb begin
    push         = inflight_q && !flush;
    push_instr   = inflight_mis_q ? NOP : imem_rdata;
    misalign_err = push && inflight_mis_q && !reset;
    id_valid     = (count_q != '0);
    pop          = id_valid && id_ready;
    id_pc        = id_valid ? pc_mem_q[rd_ptr_q]    : last_pc_q;
    id_instr     = id_valid ? instr_mem_q[rd_ptr_q] : last_instr_q;
    id_pc_plus4  = id_pc + ADDR_W'(4);
  end

  // FIFO bookkeeping
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      inflight_q     <= 1'b0;
      inflight_pc_q  <= '0;
      inflight_mis_q <= 1'b0;
      last_pc_q      <= '0;
      last_instr_q   <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      // accept is already blocked during flush, so this also drops the in-flight read
      inflight_q <= accept;
      if (accept) begin
        inflight_pc_q  <= pc_in;
        inflight_mis_q <= (pc_in[1:0] != 2'b00);
      end
      if (id_valid) begin
        last_pc_q    <= pc_mem_q[rd_ptr_q];
        last_instr_q <= instr_mem_q[rd_ptr_q];
      end
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
      instr_mem_q[wr_ptr_q] <= push_instr;
    end
  end

endmodule

// File: tb/tb_fetch_buffer_stage.sv
module tb_fetch_buffer_stage;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned DEPTH   = 2;
  localparam logic [31:0] NOP     = 32'h0000_0000;

  logic               clock = 1'b0;
  logic               reset;
  logic [ADDR_W-1:0]  pc_in;
  logic               pc_valid;
  logic               pc_ready;
  logic               imem_en;
  logic [ADDR_W-3:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               flush;
  logic               id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] id_instr;
  logic [ADDR_W-1:0]  id_pc;
  logic [ADDR_W-1:0]  id_pc_plus4;
  logic               misalign_err;

  fetch_buffer_stage #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W),
    .DEPTH  (DEPTH),
    .NOP    (NOP)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pc_in       (pc_in),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .misalign_err(misalign_err)
  );

  always #5 clock = ~clock;

  // Synchronous instruction memory, one-cycle read latency
  logic [31:0] mem [64];
  always @(posedge clock) if (imem_en) imem_rdata <= mem[imem_addr];

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] instr;
  } entry_t;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] instr;
    logic [7:0]  plus4;
  } seen_t;

  // Reference model: queue of entries plus one pending fetch
  entry_t     model_q[$];
  bit         pend_v;
  logic [7:0] pend_pc;
  bit         known;

  logic [7:0] feed_q[$];
  seen_t      seen_q[$];
  int         n_checks, n_pass;
  int         cyc, n_mis, n_acc_obs, first_acc, first_val;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic cycle(input bit pv, input logic [7:0] pc, input bit rdy, input bit fl,
                       input bit rst, output bit acc);
    bit     exp_ready, exp_acc, exp_mis;
    entry_t e;
    reset    = rst;
    pc_valid = pv;
    pc_in    = pc;
    id_ready = rdy;
    flush    = fl;
    exp_ready = !rst && !fl && ((model_q.size() + int'(pend_v)) < DEPTH);
    exp_acc   = pv && exp_ready;
    exp_mis   = !rst && !fl && pend_v && (pend_pc[1:0] != 2'b00);
    @(negedge clock);
    check_eq("pc_ready", 32'(pc_ready), 32'(exp_ready));
    check_eq("imem_en", 32'(imem_en), 32'(exp_acc));
    if (exp_acc) check_eq("imem_addr", 32'(imem_addr), 32'(pc[7:2]));
    check_eq("misalign_err", 32'(misalign_err), 32'(exp_mis));
    if (known) begin
      check_eq("id_valid", 32'(id_valid), 32'(model_q.size() != 0));
      if (model_q.size() != 0) begin
        e = model_q[0];
        check_eq("id_pc", 32'(id_pc), 32'(e.pc));
        check_eq("id_instr", id_instr, e.instr);
        check_eq("id_pc_plus4", 32'(id_pc_plus4), 32'(8'(e.pc + 8'd4)));
      end
    end
    if (misalign_err) n_mis++;
    if (pc_valid && pc_ready) begin
      n_acc_obs++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (id_valid && first_val < 0) first_val = cyc;
    if (id_valid && id_ready) seen_q.push_back({id_pc, id_instr, id_pc_plus4});
    acc = exp_acc;
    @(posedge clock);
    if (rst) begin
      model_q.delete();
      pend_v = 1'b0;
      known  = 1'b1;
    end else begin
      if (model_q.size() != 0 && rdy) void'(model_q.pop_front());
      if (fl) begin
        model_q.delete();
        pend_v = 1'b0;
      end else begin
        if (pend_v) begin
          e.pc    = pend_pc;
          e.instr = (pend_pc[1:0] != 2'b00) ? NOP : mem[pend_pc[7:2]];
          model_q.push_back(e);
        end
        pend_v  = exp_acc;
        pend_pc = pc;
      end
    end
    cyc++;
    #1;
  endtask

  // Presents the head of feed_q and advances it on acceptance
  task automatic tick(input bit rdy, input bit fl, input bit rst);
    bit acc;
    logic [7:0] pc;
    pc = (feed_q.size() != 0) ? feed_q[0] : 8'h00;
    cycle(feed_q.size() != 0, pc, rdy, fl, rst, acc);
    if (acc) void'(feed_q.pop_front());
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((feed_q.size() != 0 || model_q.size() != 0 || pend_v) && budget < 50) begin
      tick(1'b1, 1'b0, 1'b0);
      budget++;
    end
    if (budget >= 50) check_eq("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic start_test();
    seen_q.delete();
    n_mis     = 0;
    n_acc_obs = 0;
    first_acc = -1;
    first_val = -1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    known    = 1'b0;
    pend_v   = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i * 4);
    reset = 1'b1; pc_valid = 1'b0; pc_in = '0; id_ready = 1'b0; flush = 1'b0;
    @(posedge clock);
    #1;
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check_eq("rst_id_valid", 32'(id_valid), 32'd0);
    check_eq("rst_id_pc", 32'(id_pc), 32'd0);
    check_eq("rst_id_instr", id_instr, 32'd0);

    // Back-to-back fetch, decode always ready
    start_test();
    feed_q = '{8'h00, 8'h04, 8'h08};
    drain();
    check_eq("t1_latency", 32'(first_val - first_acc), 32'd2);
    check_eq("t1_count", 32'(seen_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < seen_q.size(); i++) begin
      check_eq("t1_pc", 32'(seen_q[i].pc), 32'(i * 4));
      check_eq("t1_plus4", 32'(seen_q[i].plus4), 32'(i * 4 + 4));
      check_eq("t1_instr", seen_q[i].instr, 32'hA000_0000 + 32'(i * 4));
    end

    // Decode stalled: only two fetches fit
    start_test();
    feed_q = '{8'h00, 8'h04, 8'h08};
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0);
    check_eq("t2_stall_accepts", 32'(n_acc_obs), 32'd2);
    drain();
    check_eq("t2_count", 32'(seen_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < seen_q.size(); i++)
      check_eq("t2_order", 32'(seen_q[i].pc), 32'(i * 4));

    // Flush kills an in-flight fetch
    start_test();
    feed_q = '{8'h10};
    tick(1'b1, 1'b0, 1'b0);
    feed_q = '{8'h40};
    tick(1'b1, 1'b1, 1'b0);
    drain();
    check_eq("t3_count", 32'(seen_q.size()), 32'd1);
    if (seen_q.size() != 0) check_eq("t3_pc", 32'(seen_q[0].pc), 32'h40);

    // Misaligned PC
    start_test();
    feed_q = '{8'h06};
    drain();
    check_eq("t4_mis_pulses", 32'(n_mis), 32'd1);
    check_eq("t4_count", 32'(seen_q.size()), 32'd1);
    if (seen_q.size() != 0) begin
      check_eq("t4_instr", seen_q[0].instr, NOP);
      check_eq("t4_pc", 32'(seen_q[0].pc), 32'h06);
      check_eq("t4_plus4", 32'(seen_q[0].plus4), 32'h0A);
    end

    // Wrap of pc + 4
    start_test();
    feed_q = '{8'hFC};
    drain();
    check_eq("t5_count", 32'(seen_q.size()), 32'd1);
    if (seen_q.size() != 0) check_eq("t5_plus4", 32'(seen_q[0].plus4), 32'h00);

    // Reset with one entry queued and one in flight
    start_test();
    feed_q = '{8'h20, 8'h24, 8'h28};
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check_eq("t6_setup", 32'(model_q.size() + int'(pend_v)), 32'd2);
    tick(1'b0, 1'b0, 1'b1);
    feed_q.delete();
    seen_q.delete();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
    check_eq("t6_no_stale", 32'(seen_q.size()), 32'd0);

    // Randomized traffic with fresh memory contents
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 800; i++) begin
      bit         pv, rdy, fl, rst, acc;
      logic [7:0] pc;
      pv  = ($urandom_range(0, 3) != 0);
      pc  = 8'($urandom);
      if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 63) == 0);
      cycle(pv, pc, rdy, fl, rst, acc);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
